ahb_spi_flash_xip: RTL



---
 rtl/ahb_spi_flash_xip.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ahb_spi_flash_xip.sv
// ahb_spi_flash_xip
// Read-only AHB-Lite slave that turns each accepted word read into one
// complete SPI READ (0x03) transaction against a serial NOR flash.
// No buffering or prefetch: one bus read, one flash transaction.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   ahbls_hready_resp/hresp  slave ready and response (hresp=1 is ERROR)
//   ahbls_hready/htrans/     address-phase controls; a transfer is accepted
//   ahbls_hwrite/haddr       when hready && htrans[1]
//   ahbls_hsize/hburst/      ignored
//   ahbls_hprot/hmastlock/
//   ahbls_hwdata
//   ahbls_hrdata             read data, little-endian assembly of 4 bytes
//   spi_cs_n/sck/mosi/miso   SPI mode 0 flash interface, outputs registered

module ahb_spi_flash_xip #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int CLKDIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ahbls_hready_resp,
  input  logic              ahbls_hready,
  output logic              ahbls_hresp,
  input  logic [W_ADDR-1:0] ahbls_haddr,
  input  logic              ahbls_hwrite,
  input  logic [1:0]        ahbls_htrans,
  input  logic [2:0]        ahbls_hsize,
  input  logic [2:0]        ahbls_hburst,
  input  logic [3:0]        ahbls_hprot,
  input  logic              ahbls_hmastlock,
  input  logic [W_DATA-1:0] ahbls_hwdata,
  output logic [W_DATA-1:0] ahbls_hrdata,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SHIFT, S_DONE, S_GAP, S_ERR0, S_ERR1
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
  localparam logic [8:0] GAP_LAST = 9'(2 * CLKDIV - 2);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [8:0]  gap_cnt;
  // Holds the outgoing bits after bit 0; bit 0 (MSB of 0x03) is always 0
  // and is driven directly on SELECT entry.
  logic [30:0] tx_sr;
  logic [31:0] rx_sr;
  logic        accept;
  logic        phase_end;
  logic        shift_last;
  logic        addr_load;

  logic unused_inputs;
  assign unused_inputs = ^{ahbls_haddr[W_ADDR-1:24], ahbls_haddr[1:0], ahbls_hsize,
                           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata};

  assign accept     = ahbls_hready && ahbls_htrans[1];
  assign phase_end  = (div_cnt == DIV_LAST);
  assign shift_last = (state == S_SHIFT) && phase_end && spi_sck && (bit_cnt == 6'd63);

  // Next-state and bus response. DONE and ERR1 both complete a data phase,
  // so either can accept the next address phase; a read accepted there has
  // to pass through GAP to guarantee the cs_n high time.
  always_comb begin
    state_nxt         = state;
    ahbls_hready_resp = 1'b1;
    ahbls_hresp       = 1'b0;
    addr_load         = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR1: begin
        if (state == S_ERR1) ahbls_hresp = 1'b1;
        if (accept) begin
          if (ahbls_hwrite) begin
            state_nxt = S_ERR0;
          end else begin
            addr_load = 1'b1;
            state_nxt = (state == S_IDLE) ? S_SELECT : S_GAP;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SELECT: begin
        ahbls_hready_resp = 1'b0;
        state_nxt         = S_SHIFT;
      end
      S_SHIFT: begin
        ahbls_hready_resp = 1'b0;
        if (shift_last) state_nxt = S_DONE;
      end
      S_GAP: begin
        ahbls_hready_resp = 1'b0;
        if (gap_cnt == GAP_LAST) state_nxt = S_SELECT;
      end
      S_ERR0: begin
        ahbls_hready_resp = 1'b0;
        ahbls_hresp       = 1'b1;
        state_nxt         = S_ERR1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register plus the SPI datapath. Within SHIFT each half-bit lasts
  // CLKDIV cycles; miso is captured on the edge that raises sck, and mosi
  // advances on the edge that lowers it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      spi_cs_n     <= 1'b1;
      spi_sck      <= 1'b0;
      spi_mosi     <= 1'b0;
      div_cnt      <= 8'd0;
      bit_cnt      <= 6'd0;
      gap_cnt      <= 9'd0;
      tx_sr        <= 31'd0;
      rx_sr        <= 32'd0;
      ahbls_hrdata <= '0;
    end else begin
      state    <= state_nxt;
      spi_cs_n <= !((state_nxt == S_SELECT) || (state_nxt == S_SHIFT));
      if (addr_load) tx_sr <= {7'b0000011, ahbls_haddr[23:2], 2'b00};
      if (state_nxt == S_SELECT && state != S_SELECT) spi_mosi <= 1'b0;
      case (state)
        S_SELECT: begin
          div_cnt <= 8'd0;
          bit_cnt <= 6'd0;
          spi_sck <= 1'b0;
        end
        S_SHIFT: begin
          if (phase_end) begin
            div_cnt <= 8'd0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
              rx_sr   <= {rx_sr[30:0], spi_miso};
            end else begin
              spi_sck <= 1'b0;
              if (bit_cnt == 6'd63) begin
                spi_mosi     <= 1'b0;
                ahbls_hrdata <= {rx_sr[7:0], rx_sr[15:8], rx_sr[23:16], rx_sr[31:24]};
              end else begin
                bit_cnt  <= bit_cnt + 6'd1;
                spi_mosi <= tx_sr[30];
                tx_sr    <= {tx_sr[29:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP:   gap_cnt <= gap_cnt + 9'd1;
        default: gap_cnt <= 9'd0;
      endcase
    end
  end

endmodule
